// File: rtl/rnd_sched.sv
// Round-robin scheduler that shares one free-running random byte source among NREQ requesters.
// Optional byte repetition health test and FAULT state when RND_HEALTH_EN is defined.
module rnd_sched #(
   parameter int unsigned NREQ         = 4,
   parameter int unsigned GAP          = 8,
   parameter int unsigned WARMUP       = 64,
   parameter int unsigned HEALTH_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [7:0]      rnd_in,
   input  logic [NREQ-1:0] req,
   input  logic            hold,
   input  logic            restart,
   output logic [NREQ-1:0] gnt,
   output logic [7:0]      rnd_out,
   output logic            rnd_valid,
   output logic            ready,
   output logic            alarm
);

   localparam int unsigned PW = $clog2(NREQ);
   localparam int unsigned SW = 8;
   localparam int unsigned WW = 16;
   localparam int unsigned RW = 4;

   // Elaboration-time range checks on the configuration.
   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("rnd_sched: NREQ out of range");
   end
   if (GAP < 1 || GAP > 255) begin : g_bad_gap
      $error("rnd_sched: GAP out of range");
   end
   if (WARMUP < 1 || WARMUP > 65535) begin : g_bad_warmup
      $error("rnd_sched: WARMUP out of range");
   end
   if (HEALTH_LIMIT < 2 || HEALTH_LIMIT > 15) begin : g_bad_limit
      $error("rnd_sched: HEALTH_LIMIT out of range");
   end

`ifdef RND_HEALTH_EN
   typedef enum logic [1:0] {ST_WARMUP, ST_RUN, ST_FAULT} state_t;
`else
   typedef enum logic [1:0] {ST_WARMUP, ST_RUN} state_t;
`endif

   state_t          state_q, state_d;
   logic [WW-1:0]   warm_q, warm_d;
   logic [SW-1:0]   spc_q, spc_d;
   logic [PW-1:0]   rr_q, rr_d;
   logic [NREQ-1:0] gnt_d;
   logic [7:0]      rnd_d;
   logic            valid_d;
   logic            ready_d;
   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   idx;
`ifdef RND_HEALTH_EN
   logic            alarm_d;
   logic [RW-1:0]   rep_q, rep_d, rep_nx;
   logic [7:0]      prev_q, prev_d;
`endif

   // Round-robin search for the first active request at or above the pointer.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         idx = PW'((32'(rr_q) + 32'(i)) % NREQ);
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      spc_d   = (spc_q != '0) ? spc_q - SW'(1) : spc_q;
      rr_d    = rr_q;
      gnt_d   = '0;
      valid_d = 1'b0;
      rnd_d   = rnd_out;
`ifdef RND_HEALTH_EN
      alarm_d = alarm;
      rep_d   = rep_q;
      prev_d  = prev_q;
      rep_nx  = (rnd_in == prev_q) ? rep_q + RW'(1) : RW'(1);
`endif
      if (restart) begin
         state_d = ST_WARMUP;
         warm_d  = WW'(WARMUP - 1);
         spc_d   = '0;
`ifdef RND_HEALTH_EN
         alarm_d = 1'b0;
         rep_d   = '0;
         prev_d  = '0;
`endif
      end else begin
         case (state_q)
            ST_WARMUP: begin
               if (warm_q == '0) state_d = ST_RUN;
               else              warm_d  = warm_q - WW'(1);
            end
            ST_RUN: begin
               if (win_found && !hold && spc_q == '0) begin
                  gnt_d   = NREQ'(1) << win_idx;
                  valid_d = 1'b1;
                  rnd_d   = rnd_in;
                  rr_d    = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
                  spc_d   = SW'(GAP - 1);
`ifdef RND_HEALTH_EN
                  rep_d   = rep_nx;
                  prev_d  = rnd_in;
                  if (rep_nx >= RW'(HEALTH_LIMIT)) begin
                     alarm_d = 1'b1;
                     state_d = ST_FAULT;
                  end
`endif
               end
            end
`ifdef RND_HEALTH_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_WARMUP;
         endcase
      end
      ready_d = (state_d == ST_RUN) && (spc_d == '0);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_WARMUP;
         warm_q    <= WW'(WARMUP - 1);
         spc_q     <= '0;
         rr_q      <= '0;
         gnt       <= '0;
         rnd_out   <= '0;
         rnd_valid <= 1'b0;
         ready     <= 1'b0;
`ifdef RND_HEALTH_EN
         alarm     <= 1'b0;
         rep_q     <= '0;
         prev_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         warm_q    <= warm_d;
         spc_q     <= spc_d;
         rr_q      <= rr_d;
         gnt       <= gnt_d;
         rnd_out   <= rnd_d;
         rnd_valid <= valid_d;
         ready     <= ready_d;
`ifdef RND_HEALTH_EN
         alarm     <= alarm_d;
         rep_q     <= rep_d;
         prev_q    <= prev_d;
`endif
      end
   end

`ifndef RND_HEALTH_EN
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_rnd_sched.sv
// Directed bench for rnd_sched: one GAP=8 instance and one GAP=1 instance on a shared clock/reset.
module tb_rnd_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] req_a = '0, req_b = '0;
   logic       hold_a = 1'b0, hold_b = 1'b0;
   logic       restart_a = 1'b0, restart_b = 1'b0;
   logic [7:0] rnd_a = '0, rnd_b = '0;
   logic [3:0] gnt_a, gnt_b;
   logic [7:0] rout_a, rout_b;
   logic       val_a, val_b, rdy_a, rdy_b, alm_a, alm_b;

   int checks = 0;
   int failures = 0;

   rnd_sched #(.NREQ(4), .GAP(8), .WARMUP(64), .HEALTH_LIMIT(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .rnd_in(rnd_a), .req(req_a), .hold(hold_a),
      .restart(restart_a), .gnt(gnt_a), .rnd_out(rout_a), .rnd_valid(val_a),
      .ready(rdy_a), .alarm(alm_a));

   rnd_sched #(.NREQ(4), .GAP(1), .WARMUP(64), .HEALTH_LIMIT(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .rnd_in(rnd_b), .req(req_b), .hold(hold_b),
      .restart(restart_b), .gnt(gnt_b), .rnd_out(rout_b), .rnd_valid(val_b),
      .ready(rdy_b), .alarm(alm_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the next gnt on dut_a and checks its latency, value and strobe.
   task automatic wait_gnt_a(input string tag, input logic [3:0] exp, input int dly);
      int n = 0;
      do begin
         tick();
         n++;
      end while (gnt_a == '0 && n < 200);
      chk({tag, "_dly"}, 32'(n), 32'(dly));
      chk({tag, "_gnt"}, 32'(gnt_a), 32'(exp));
      chk({tag, "_vld"}, 32'(val_a), 32'(1));
   endtask

   initial begin
      int early;
      logic [3:0] alt [4];
      logic [7:0] alt_rnd [4];
      alt[0] = 4'b0001; alt[1] = 4'b0100; alt[2] = 4'b0001; alt[3] = 4'b0100;
      alt_rnd[0] = 8'h11; alt_rnd[1] = 8'h22; alt_rnd[2] = 8'h33; alt_rnd[3] = 8'h44;

      // Reset state
      tick();
      chk("rst_gnt", 32'(gnt_a), 32'(0));
      chk("rst_rout", 32'(rout_a), 32'(0));
      chk("rst_vld", 32'(val_a), 32'(0));
      chk("rst_rdy", 32'(rdy_a), 32'(0));
      chk("rst_alm", 32'(alm_a), 32'(0));

      // Test 1: first grant 65 clocks after reset release, byte from decision edge
      req_a = 4'b0001;
      tick();
      rst_n = 1'b1;
      early = 0;
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (gnt_a != '0) early++;
         if (k == 63) chk("t1_rdy63", 32'(rdy_a), 32'(0));
         if (k == 64) chk("t1_rdy64", 32'(rdy_a), 32'(1));
         rnd_a = 8'(k);
      end
      chk("t1_early", 32'(early), 32'(0));
      tick();
      chk("t1_gnt", 32'(gnt_a), 32'(4'b0001));
      chk("t1_vld", 32'(val_a), 32'(1));
      chk("t1_rout", 32'(rout_a), 32'(8'h40));
      req_a = '0;
      tick();
      chk("t1_pulse_gnt", 32'(gnt_a), 32'(0));
      chk("t1_pulse_vld", 32'(val_a), 32'(0));
      chk("t1_rout_hold", 32'(rout_a), 32'(8'h40));
      chk("t1_rdy_gap", 32'(rdy_a), 32'(0));

      // Test 2: rotation with all requests held, 8 clocks apart
      rst_n = 1'b0;
      tick();
      req_a = 4'b1111;
      rst_n = 1'b1;
      wait_gnt_a("t2_g0", 4'b0001, 65);
      wait_gnt_a("t2_g1", 4'b0010, 8);
      wait_gnt_a("t2_g2", 4'b0100, 8);
      wait_gnt_a("t2_g3", 4'b1000, 8);
      wait_gnt_a("t2_g4", 4'b0001, 8);

      // Test 4: hold blocks grants but ready still rises
      req_a = 4'b0010;
      hold_a = 1'b1;
      early = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (gnt_a != '0) early++;
      end
      chk("t4_nognt", 32'(early), 32'(0));
      chk("t4_rdy", 32'(rdy_a), 32'(1));
      hold_a = 1'b0;
      tick();
      chk("t4_gnt", 32'(gnt_a), 32'(4'b0010));

      // Test 5: restart re-enters warm-up and keeps the rr pointer (now 2)
      req_a = 4'b1010;
      restart_a = 1'b1;
      tick();
      restart_a = 1'b0;
      chk("t5_gnt0", 32'(gnt_a), 32'(0));
      chk("t5_rdy0", 32'(rdy_a), 32'(0));
      chk("t5_alm", 32'(alm_a), 32'(0));
      wait_gnt_a("t5_first", 4'b1000, 65);
      req_a = '0;

      // Test 3: GAP=1 alternates every cycle
      req_b = 4'b0101;
      for (int k = 0; k < 4; k++) begin
         rnd_b = alt_rnd[k];
         tick();
         chk($sformatf("t3_gnt%0d", k), 32'(gnt_b), 32'(alt[k]));
         chk($sformatf("t3_vld%0d", k), 32'(val_b), 32'(1));
         chk($sformatf("t3_rout%0d", k), 32'(rout_b), 32'(alt_rnd[k]));
      end
      req_b = 4'b0100;
      tick();
      chk("t3_sole0", 32'(gnt_b), 32'(4'b0100));
      tick();
      chk("t3_sole1", 32'(gnt_b), 32'(4'b0100));
      req_b = '0;
      tick();
      chk("t3_idle_gnt", 32'(gnt_b), 32'(0));
      chk("t3_idle_vld", 32'(val_b), 32'(0));
      chk("t3_alm_off", 32'(alm_b), 32'(0));

`ifdef RND_HEALTH_EN
      // Test 6: repeated byte trips the alarm on the 4th grant
      rnd_b = 8'hA5;
      req_b = 4'b0001;
      restart_b = 1'b1;
      tick();
      restart_b = 1'b0;
      early = 0;
      do begin
         tick();
         early++;
      end while (gnt_b == '0 && early < 200);
      chk("t6_dly", 32'(early), 32'(65));
      chk("t6_alm1", 32'(alm_b), 32'(0));
      tick();
      chk("t6_gnt2", 32'(gnt_b), 32'(4'b0001));
      tick();
      chk("t6_alm3", 32'(alm_b), 32'(0));
      tick();
      chk("t6_gnt4", 32'(gnt_b), 32'(4'b0001));
      chk("t6_alm4", 32'(alm_b), 32'(1));
      tick();
      chk("t6_fault_gnt", 32'(gnt_b), 32'(0));
      chk("t6_fault_rdy", 32'(rdy_b), 32'(0));
      chk("t6_sticky", 32'(alm_b), 32'(1));
      restart_b = 1'b1;
      tick();
      restart_b = 1'b0;
      chk("t6_clear", 32'(alm_b), 32'(0));
      req_b = '0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
